// File: rtl/trng_reg_pkg.sv
// Shared definitions for the TRNG register bank: lane arithmetic and error classes.
package trng_reg_pkg;

  localparam int BYTE_WIDTH_DEFAULT = 8;

  function automatic int lanes(input int width, input int byte_width = BYTE_WIDTH_DEFAULT);
    return (width - 1) / byte_width + 1;
  endfunction

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_LOCKED,
    ERR_RANGE
  } reg_err_e;

endpackage

// File: rtl/byte_write_reg_entry.sv
// One bank entry: WIDTH-bit register with per-lane write enables and a sticky lock.
module byte_write_reg_entry
  import trng_reg_pkg::*;
#(
  parameter int              WIDTH       = 32,
  parameter int              BYTE_WIDTH  = BYTE_WIDTH_DEFAULT,
  parameter int              WE_WIDTH    = lanes(WIDTH, BYTE_WIDTH),
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WE_WIDTH-1:0] lane_en,
  input  logic [WIDTH-1:0]    d,
  input  logic                lock_set,
  output logic [WIDTH-1:0]    q,
  output logic                locked
);

  logic [WIDTH-1:0] bit_en;

  // The top lane is clipped naturally: only bits below WIDTH exist.
  always_comb begin
    bit_en = '0;
    for (int i = 0; i < WIDTH; i++) bit_en[i] = lane_en[i / BYTE_WIDTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q      <= RESET_VALUE;
      locked <= 1'b0;
    end else begin
      if (!locked) q <= (q & ~bit_en) | (d & bit_en);
      if (lock_set) locked <= 1'b1;
    end
  end

endmodule

// File: rtl/byte_write_reg_bank.sv
// Addressed bank of byte-writable registers with registered read, sticky locks and error pulse.
// Define BYTE_WRITE_REG_BANK_FWD_EN for write-first same-address read/write (default is read-first).
module byte_write_reg_bank
  import trng_reg_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               BYTE_WIDTH  = BYTE_WIDTH_DEFAULT,
  parameter int               DEPTH       = 8,
  localparam int              WE_WIDTH    = lanes(WIDTH, BYTE_WIDTH),
  localparam int              ADDR_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WE_WIDTH-1:0]   we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      d_i,
  input  logic                  lock_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      d_o,
  output logic                  valid_o,
  output logic                  err_o,
  output logic [DEPTH-1:0]      lock_o
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0] q [DEPTH];
  logic [DEPTH-1:0] locked;
  logic             w_in_range, r_in_range, wr_any, wr_locked;
  logic [WIDTH-1:0] rd_data;
  reg_err_e         err_kind;

  assign w_in_range = {1'b0, waddr_i} < DEPTH_L;
  assign r_in_range = {1'b0, raddr_i} < DEPTH_L;
  assign wr_any     = |we_i;
  assign lock_o     = locked;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    logic sel;
    assign sel = w_in_range && (waddr_i == ADDR_WIDTH'(g));
    byte_write_reg_entry #(
      .WIDTH      (WIDTH),
      .BYTE_WIDTH (BYTE_WIDTH),
      .WE_WIDTH   (WE_WIDTH),
      .RESET_VALUE(RESET_VALUE)
    ) u_entry (
      .clk     (clk),
      .rst     (rst),
      .lane_en (sel ? we_i : '0),
      .d       (d_i),
      .lock_set(sel && lock_i),
      .q       (q[g]),
      .locked  (locked[g])
    );
  end

  always_comb begin
    wr_locked = 1'b0;
    rd_data   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (waddr_i == ADDR_WIDTH'(k)) wr_locked = locked[k];
      if (raddr_i == ADDR_WIDTH'(k)) rd_data = q[k];
    end
`ifdef BYTE_WRITE_REG_BANK_FWD_EN
    // Forward only writes that will actually land (in range, unlocked).
    if (wr_any && w_in_range && !wr_locked && (waddr_i == raddr_i)) begin
      for (int i = 0; i < WIDTH; i++)
        if (we_i[i / BYTE_WIDTH]) rd_data[i] = d_i[i];
    end
`endif
  end

  always_comb begin
    err_kind = ERR_NONE;
    if (wr_any && w_in_range && wr_locked) err_kind = ERR_LOCKED;
    if (((wr_any || lock_i) && !w_in_range) || (re_i && !r_in_range)) err_kind = ERR_RANGE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_o     <= '0;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      valid_o <= re_i && r_in_range;
      if (re_i && r_in_range) d_o <= rd_data;
      err_o   <= (err_kind != ERR_NONE);
    end
  end

endmodule

// File: tb/tb_byte_write_reg_bank.sv
// Bench for byte_write_reg_bank (DEPTH=6): directed steps then random traffic against a lane-level model.
module tb_byte_write_reg_bank;

  localparam int W = 32, BW = 8, DEPTH = 6, AW = 3, NL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NL-1:0] we_i;
  logic [AW-1:0] waddr_i, raddr_i;
  logic [W-1:0]  d_i, d_o;
  logic          lock_i, re_i, valid_o, err_o;
  logic [DEPTH-1:0] lock_o;

  int total = 0;
  int bad   = 0;

  logic [W-1:0]     mem [DEPTH];
  logic [DEPTH-1:0] mlock;
  logic [W-1:0]     exp_d;
  logic             exp_valid, exp_err;
  logic [W-1:0]     exp_q [$];

  always #5 clk = ~clk;

  byte_write_reg_bank #(.WIDTH(W), .BYTE_WIDTH(BW), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .d_i(d_i), .lock_i(lock_i),
    .re_i(re_i), .raddr_i(raddr_i), .d_o(d_o), .valid_o(valid_o), .err_o(err_o), .lock_o(lock_o)
  );

  function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] nd,
                                         input logic [NL-1:0] we);
    logic [W-1:0] r;
    r = old;
    for (int l = 0; l < NL; l++) if (we[l]) r[l*BW +: BW] = nd[l*BW +: BW];
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    mlock     = '0;
    exp_d     = '0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    exp_q.delete();
  endtask

  task automatic drive_idle();
    we_i = '0; waddr_i = '0; d_i = '0; lock_i = 1'b0; re_i = 1'b0; raddr_i = '0;
  endtask

  // One bus cycle: drive, clock, advance the model, then compare every output.
  task automatic cycle(input logic [NL-1:0] we, input int waddr, input logic [W-1:0] d,
                       input logic lk, input logic re, input int raddr);
    logic wr, w_ok, r_ok, w_lk;
    we_i = we; waddr_i = AW'(waddr); d_i = d; lock_i = lk; re_i = re; raddr_i = AW'(raddr);
    @(posedge clk);
    wr   = (we != '0);
    w_ok = (waddr < DEPTH);
    r_ok = (raddr < DEPTH);
    w_lk = w_ok ? mlock[waddr] : 1'b0;
    exp_err = (wr && w_ok && w_lk) || ((wr || lk) && !w_ok) || (re && !r_ok);
    exp_valid = re && r_ok;
    if (exp_valid) begin
      exp_d = mem[raddr];
`ifdef BYTE_WRITE_REG_BANK_FWD_EN
      if (wr && w_ok && !w_lk && waddr == raddr) exp_d = merge(mem[raddr], d, we);
`endif
      exp_q.push_back(exp_d);
    end
    if (wr && w_ok && !w_lk) mem[waddr] = merge(mem[waddr], d, we);
    if (lk && w_ok) mlock[waddr] = 1'b1;
    #1;
    check("valid_o", W'(valid_o), W'(exp_valid));
    check("err_o", W'(err_o), W'(exp_err));
    check("lock_o", W'(lock_o), W'(mlock));
    check("d_o", d_o, exp_d);
    if (exp_valid) check("read_data", d_o, exp_q.pop_front());
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check("reset_d_o", d_o, '0);
    check("reset_valid", W'(valid_o), '0);
    check("reset_err", W'(err_o), '0);
    check("reset_lock", W'(lock_o), '0);

    for (int a = 0; a < DEPTH; a++) cycle('0, 0, '0, 1'b0, 1'b1, a);

    // Partial lane write
    cycle(4'b1111, 3, 32'hAABBCCDD, 1'b0, 1'b0, 0);
    cycle(4'b0101, 3, 32'h11223344, 1'b0, 1'b0, 0);
    cycle('0, 0, '0, 1'b0, 1'b1, 3);
    check("partial_write", d_o, 32'hAA22CC44);

    // Same-address read and write in one cycle
    cycle(4'b0001, 2, 32'h000000FF, 1'b0, 1'b1, 2);
`ifdef BYTE_WRITE_REG_BANK_FWD_EN
    check("same_cycle_fwd", d_o, 32'h000000FF);
`else
    check("same_cycle_rf", d_o, 32'h00000000);
`endif

    // Out-of-range write, then out-of-range read with d_o holding
    cycle(4'b1111, 7, 32'hDEADBEEF, 1'b0, 1'b0, 0);
    check("range_write_err", W'(err_o), W'(1'b1));
    for (int a = 0; a < DEPTH; a++) cycle('0, 0, '0, 1'b0, 1'b1, a);
    cycle('0, 0, '0, 1'b0, 1'b1, 3);
    cycle('0, 0, '0, 1'b0, 1'b1, 6);
    check("range_read_err", W'(err_o), W'(1'b1));
    check("range_read_valid", W'(valid_o), '0);
    check("range_read_hold", d_o, 32'hAA22CC44);

    // Lock with write, then a rejected write
    cycle(4'b1111, 5, 32'h12345678, 1'b1, 1'b0, 0);
    cycle(4'b1111, 5, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
    check("locked_write_err", W'(err_o), W'(1'b1));
    cycle('0, 0, '0, 1'b0, 1'b0, 0);
    check("err_single_pulse", W'(err_o), '0);
    cycle('0, 0, '0, 1'b0, 1'b1, 5);
    check("locked_read", d_o, 32'h12345678);
    check("lock_bit5", W'(lock_o[5]), W'(1'b1));

    // Reset in the middle of a read
    we_i = '0; lock_i = 1'b0; re_i = 1'b1; raddr_i = AW'(3);
    #3 rst = 1'b0;
    #1;
    check("midreset_valid", W'(valid_o), '0);
    check("midreset_d_o", d_o, '0);
    check("midreset_err", W'(err_o), '0);
    check("midreset_lock", W'(lock_o), '0);
    model_reset();
    drive_idle();
    @(posedge clk);
    #1 rst = 1'b1;
    for (int a = 0; a < DEPTH; a++) cycle('0, 0, '0, 1'b0, 1'b1, a);
    check("post_reset_lock", W'(lock_o), '0);

    // Random traffic, including out-of-range addresses and same-address collisions
    repeat (400) begin
      int wa;
      wa = $urandom_range(0, 7);
      cycle(NL'($urandom_range(0, 15)), wa, $urandom, ($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? wa : $urandom_range(0, 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
